// File: rtl/fdas_ddr_arb_pkg.sv
// Shared types and helpers for the FDAS DDR Avalon-MM arbiter.
package fdas_ddr_arb_pkg;

  localparam int unsigned MAX_PORTS   = 8;
  localparam int unsigned PORT_IDX_W  = 3;
  localparam int unsigned IDX_W       = PORT_IDX_W + 1;
  localparam int unsigned TAG_BURST_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CMD   = 2'd1,
    WR_BURST = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [PORT_IDX_W-1:0]  port;
    logic [TAG_BURST_W-1:0] burstcount;
  } tag_t;

  // First requester at or after ptr, wrapping within n ports; returns ptr when idle.
  function automatic logic [PORT_IDX_W-1:0] rr_pick(
    input logic [MAX_PORTS-1:0]  req,
    input logic [PORT_IDX_W-1:0] ptr,
    input int unsigned           n
  );
    logic [PORT_IDX_W-1:0] pick;
    logic                  found;
    logic [IDX_W-1:0]      idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      idx = {1'b0, ptr} + IDX_W'(i);
      if (idx >= IDX_W'(n)) idx = idx - IDX_W'(n);
      if (!found && (i < n) && req[idx[PORT_IDX_W-1:0]]) begin
        pick  = idx[PORT_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fdas_ddr_amm_arbiter_if.sv
// Avalon-MM bus bundle; N lanes of command signals, shared readdata.
interface fdas_ddr_amm_arbiter_if #(
  parameter int unsigned N       = 1,
  parameter int unsigned DATA_W  = 576,
  parameter int unsigned ADDR_W  = 27,
  parameter int unsigned BURST_W = 7
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [N-1:0]         read;
  logic [N-1:0]         write;
  logic [N*ADDR_W-1:0]  address;
  logic [N*DATA_W-1:0]  writedata;
  logic [N*BURST_W-1:0] burstcount;
  logic [N*BE_W-1:0]    byteenable;
  logic [N-1:0]         ready;
  logic [DATA_W-1:0]    readdata;
  logic [N-1:0]         readdatavalid;

  modport master (
    output read, write, address, writedata, burstcount, byteenable,
    input  ready, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, writedata, burstcount, byteenable,
    output ready, readdata, readdatavalid
  );
endinterface

// File: rtl/fdas_ddr_arb_tag_fifo.sv
// Tag FIFO of outstanding read commands (port, burst length); push and pop may coincide.
module fdas_ddr_arb_tag_fifo
  import fdas_ddr_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  tag_t                         push_tag,
  input  logic                         pop,
  output tag_t                         head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fdas_ddr_amm_arbiter.sv
// Round-robin N-port Avalon-MM arbiter in front of the EMIF user port, with read-return routing.
// Optional per-port statistics counters: define FDAS_DDR_ARB_STATS_EN.
module fdas_ddr_amm_arbiter
  import fdas_ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 576,
  parameter int unsigned ADDR_W    = 27,
  parameter int unsigned BURST_W   = 7,
  parameter int unsigned RDQ_DEPTH = 16
) (
  input  logic                               emif_usr_clk,
  input  logic                               emif_usr_reset_n,
  fdas_ddr_amm_arbiter_if.slave              s,
  fdas_ddr_amm_arbiter_if.master             m,
  output logic [$clog2(RDQ_DEPTH+1)-1:0]     rd_outstanding,
  output logic                               rd_orphan_err
`ifdef FDAS_DDR_ARB_STATS_EN
  ,
  input  logic                               stat_clr,
  output logic [NUM_PORTS*32-1:0]            stat_rd_cmds,
  output logic [NUM_PORTS*32-1:0]            stat_wr_beats
`endif
);
  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e              state;
  logic [PORT_IDX_W-1:0]   gnt;
  logic [PORT_IDX_W-1:0]   rr_ptr;
  logic [PORT_IDX_W-1:0]   pick;
  logic [MAX_PORTS-1:0]    req;
  logic                    pick_rd;
  logic [NUM_PORTS-1:0]    gnt_oh;
  logic                    gnt_wr;
  logic [BURST_W-1:0]      gnt_bc;
  logic [BURST_W-1:0]      gnt_bc_eff;
  logic [BURST_W-1:0]      beats_left;
  logic                    wr_active;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    tag_full;
  logic                    tag_empty;
  tag_t                    push_tag;
  tag_t                    head;
  logic                    rtn_beat;
  logic                    pop;
  logic [TAG_BURST_W-1:0]  rtn_cnt;

  // Arbitration decode and the zero-latency command/return muxes.
  always_comb begin
    req        = MAX_PORTS'(s.read | s.write);
    pick       = rr_pick(req, rr_ptr, NUM_PORTS);
    pick_rd    = |(s.read & (NUM_PORTS'(1) << pick));
    gnt_oh     = NUM_PORTS'(1) << gnt;
    gnt_wr     = |(s.write & gnt_oh);
    gnt_bc     = BURST_W'(s.burstcount >> (32'(gnt) * BURST_W));
    gnt_bc_eff = (gnt_bc == '0) ? BURST_W'(1) : gnt_bc;

    m.address    = ADDR_W'(s.address >> (32'(gnt) * ADDR_W));
    m.writedata  = DATA_W'(s.writedata >> (32'(gnt) * DATA_W));
    m.burstcount = gnt_bc;
    m.byteenable = BE_W'(s.byteenable >> (32'(gnt) * BE_W));
    m.read       = 1'b0;
    m.write      = 1'b0;
    s.ready      = '0;
    rd_acc       = 1'b0;
    wr_acc       = 1'b0;

    case (state)
      RD_CMD: begin
        m.read  = ~tag_full;
        s.ready = gnt_oh & {NUM_PORTS{m.ready[0] & ~tag_full}};
        rd_acc  = m.ready[0] & ~tag_full;
      end
      WR_BURST: begin
        m.write = gnt_wr;
        s.ready = gnt_oh & {NUM_PORTS{m.ready[0]}};
        wr_acc  = gnt_wr & m.ready[0];
      end
      default: ;
    endcase

    push_tag.port       = gnt;
    push_tag.burstcount = TAG_BURST_W'(gnt_bc_eff);

    s.readdata      = m.readdata;
    rtn_beat        = m.readdatavalid[0] & ~tag_empty;
    s.readdatavalid = NUM_PORTS'(rtn_beat) << head.port;
    pop             = rtn_beat & ((rtn_cnt + TAG_BURST_W'(1)) == head.burstcount);
  end

  // Grant FSM; a write grant is held until the last beat regardless of s_write gaps.
  always_ff @(posedge emif_usr_clk) begin
    if (!emif_usr_reset_n) begin
      state         <= IDLE;
      gnt           <= '0;
      rr_ptr        <= '0;
      beats_left    <= '0;
      wr_active     <= 1'b0;
      rtn_cnt       <= '0;
      rd_orphan_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= pick;
            rr_ptr    <= (32'(pick) == NUM_PORTS - 1) ? '0 : pick + PORT_IDX_W'(1);
            state     <= pick_rd ? RD_CMD : WR_BURST;
            wr_active <= 1'b0;
          end
        end
        RD_CMD: begin
          if (rd_acc) state <= IDLE;
        end
        WR_BURST: begin
          if (wr_acc) begin
            if (!wr_active) begin
              if (gnt_bc_eff == BURST_W'(1)) begin
                state <= IDLE;
              end else begin
                beats_left <= gnt_bc_eff - BURST_W'(1);
                wr_active  <= 1'b1;
              end
            end else if (beats_left == BURST_W'(1)) begin
              state     <= IDLE;
              wr_active <= 1'b0;
            end else begin
              beats_left <= beats_left - BURST_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (pop)           rtn_cnt <= '0;
      else if (rtn_beat) rtn_cnt <= rtn_cnt + TAG_BURST_W'(1);

      if (m.readdatavalid[0] && tag_empty) rd_orphan_err <= 1'b1;
    end
  end

  fdas_ddr_arb_tag_fifo #(
    .DEPTH (RDQ_DEPTH)
  ) u_tag_fifo (
    .clk      (emif_usr_clk),
    .rst_n    (emif_usr_reset_n),
    .push     (rd_acc),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (rd_outstanding)
  );

`ifdef FDAS_DDR_ARB_STATS_EN
  // Per-port saturating counters; clear wins over a same-cycle increment.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stats
    logic [31:0] rd_q;
    logic [31:0] wr_q;

    always_ff @(posedge emif_usr_clk) begin
      if (!emif_usr_reset_n || stat_clr) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (rd_acc && gnt_oh[p] && (rd_q != '1)) rd_q <= rd_q + 32'd1;
        if (wr_acc && gnt_oh[p] && (wr_q != '1)) wr_q <= wr_q + 32'd1;
      end
    end

    assign stat_rd_cmds[p*32 +: 32]  = rd_q;
    assign stat_wr_beats[p*32 +: 32] = wr_q;
  end
`endif

endmodule

// File: tb/tb_fdas_ddr_amm_arbiter.sv
// Directed bench for fdas_ddr_amm_arbiter: vector table plus multi-cycle corner sequences.
module tb_fdas_ddr_amm_arbiter;

  localparam int unsigned NP    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 27;
  localparam int unsigned BW    = 7;
  localparam int unsigned BEW   = DW / 8;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rd_outstanding;
  logic       rd_orphan_err;

  always #5 clk = ~clk;

  fdas_ddr_amm_arbiter_if #(.N(NP), .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) s_bus ();
  fdas_ddr_amm_arbiter_if #(.N(1),  .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) m_bus ();

`ifdef FDAS_DDR_ARB_STATS_EN
  logic              stat_clr;
  logic [NP*32-1:0]  stat_rd_cmds;
  logic [NP*32-1:0]  stat_wr_beats;
`endif

  fdas_ddr_amm_arbiter #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .BURST_W   (BW),
    .RDQ_DEPTH (DEPTH)
  ) dut (
    .emif_usr_clk     (clk),
    .emif_usr_reset_n (rst_n),
    .s                (s_bus),
    .m                (m_bus),
    .rd_outstanding   (rd_outstanding),
    .rd_orphan_err    (rd_orphan_err)
`ifdef FDAS_DDR_ARB_STATS_EN
    ,
    .stat_clr         (stat_clr),
    .stat_rd_cmds     (stat_rd_cmds),
    .stat_wr_beats    (stat_wr_beats)
`endif
  );

  typedef struct {
    logic [3:0]    rd;
    logic          mrdv;
    logic [3:0]    e_ready;
    logic          e_mread;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_rdv;
    logic [4:0]    e_out;
  } vec_t;

  vec_t vt [13];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Request one read on port p and wait (bounded) until it is accepted.
  task automatic issue_read(input logic [1:0] p, input logic [BW-1:0] bc);
    logic done;
    done = 1'b0;
    s_bus.burstcount[32'(p)*BW +: BW] = bc;
    s_bus.read[p] = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      settle();
      if (s_bus.ready[p]) done = 1'b1;
      cyc();
    end
    s_bus.read[p] = 1'b0;
    check($sformatf("issue_read_p%0d_accept", p), 64'(done), 64'd1);
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    vt[0]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 27'h000, 4'b0000, 5'd0};
    vt[1]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 27'h100, 4'b0000, 5'd0};
    vt[2]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 27'h000, 4'b0000, 5'd1};
    vt[3]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 27'h102, 4'b0000, 5'd1};
    vt[4]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 27'h000, 4'b0000, 5'd2};
    vt[5]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 27'h100, 4'b0000, 5'd2};
    vt[6]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 27'h000, 4'b0000, 5'd3};
    vt[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 27'h102, 4'b0001, 5'd3};
    vt[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 27'h000, 4'b0000, 5'd3};
    vt[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 27'h000, 4'b0100, 5'd3};
    vt[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 27'h000, 4'b0001, 5'd2};
    vt[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 27'h000, 4'b0100, 5'd1};
    vt[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 27'h000, 4'b0000, 5'd0};

    rst_n                 = 1'b0;
    s_bus.read            = '0;
    s_bus.write           = '0;
    s_bus.byteenable      = '1;
    m_bus.ready           = 1'b1;
    m_bus.readdata        = '0;
    m_bus.readdatavalid   = 1'b0;
`ifdef FDAS_DDR_ARB_STATS_EN
    stat_clr              = 1'b0;
`endif
    for (int p = 0; p < int'(NP); p++) begin
      s_bus.address[p*AW +: AW]    = AW'(32'h100 + p);
      s_bus.writedata[p*DW +: DW]  = DW'(32'hA000_0000 + p);
      s_bus.burstcount[p*BW +: BW] = BW'(1);
    end

    // Reset state with requests and a stray return beat present.
    s_bus.read          = 4'b0101;
    m_bus.readdatavalid = 1'b1;
    cyc();
    cyc();
    settle();
    check("rst_s_ready", 64'(s_bus.ready), 64'd0);
    check("rst_m_read", 64'(m_bus.read), 64'd0);
    check("rst_m_write", 64'(m_bus.write), 64'd0);
    check("rst_rdv", 64'(s_bus.readdatavalid), 64'd0);
    check("rst_outstanding", 64'(rd_outstanding), 64'd0);
    check("rst_orphan", 64'(rd_orphan_err), 64'd0);
    m_bus.readdatavalid = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Alternating grants 0,2 with one IDLE bubble, push+pop overlap, then return drain.
    for (int i = 0; i < 13; i++) begin
      s_bus.read          = vt[i].rd;
      m_bus.readdatavalid = vt[i].mrdv;
      settle();
      check($sformatf("vec%0d_s_ready", i), 64'(s_bus.ready), 64'(vt[i].e_ready));
      check($sformatf("vec%0d_m_read", i), 64'(m_bus.read), 64'(vt[i].e_mread));
      check($sformatf("vec%0d_m_write", i), 64'(m_bus.write), 64'd0);
      check($sformatf("vec%0d_rdv", i), 64'(s_bus.readdatavalid), 64'(vt[i].e_rdv));
      check($sformatf("vec%0d_outstanding", i), 64'(rd_outstanding), 64'(vt[i].e_out));
      if (vt[i].e_mread)
        check($sformatf("vec%0d_m_address", i), 64'(m_bus.address), 64'(vt[i].e_addr));
      cyc();
    end

    // Port 1 write burst of 8 with a 2-cycle gap; port 3 waits for the whole burst.
    s_bus.burstcount[1*BW +: BW] = BW'(8);
    s_bus.write = 4'b0010;
    settle();
    check("wr_idle_ready", 64'(s_bus.ready), 64'd0);
    cyc();
    s_bus.read = 4'b1000;
    for (int b = 1; b <= 10; b++) begin
      s_bus.write[1] = (b == 3 || b == 4) ? 1'b0 : 1'b1;
      settle();
      check($sformatf("wr_b%0d_m_write", b), 64'(m_bus.write), 64'((b == 3 || b == 4) ? 0 : 1));
      check($sformatf("wr_b%0d_s_ready", b), 64'(s_bus.ready), 64'h2);
      check($sformatf("wr_b%0d_m_read", b), 64'(m_bus.read), 64'd0);
      if (b == 1) begin
        check("wr_m_address", 64'(m_bus.address), 64'h101);
        check("wr_m_burstcount", 64'(m_bus.burstcount), 64'd8);
        check("wr_m_writedata", 64'(m_bus.writedata), 64'hA000_0001);
      end
      cyc();
    end
    s_bus.write = '0;
    settle();
    check("wr_done_s_ready", 64'(s_bus.ready), 64'd0);
    check("wr_done_m_write", 64'(m_bus.write), 64'd0);
    cyc();
    settle();
    check("p3_grant_s_ready", 64'(s_bus.ready), 64'h8);
    check("p3_grant_m_read", 64'(m_bus.read), 64'd1);
    check("p3_grant_m_address", 64'(m_bus.address), 64'h103);
    cyc();
    s_bus.read = '0;
    m_bus.readdatavalid = 1'b1;
    settle();
    check("p3_return_rdv", 64'(s_bus.readdatavalid), 64'h8);
    cyc();
    m_bus.readdatavalid = 1'b0;

    // Port 0 burst 4 then port 3 burst 2; six beats route 0001 x4 then 1000 x2.
    issue_read(2'd0, BW'(4));
    issue_read(2'd3, BW'(2));
    settle();
    check("burst_outstanding", 64'(rd_outstanding), 64'd2);
    for (int k = 0; k < 6; k++) begin
      m_bus.readdatavalid = 1'b1;
      m_bus.readdata      = DW'(32'hD000_0000 + k);
      settle();
      check($sformatf("burst_beat%0d_rdv", k), 64'(s_bus.readdatavalid), 64'((k < 4) ? 4'b0001 : 4'b1000));
      check($sformatf("burst_beat%0d_data", k), 64'(s_bus.readdata), 64'(32'hD000_0000 + k));
      cyc();
    end
    m_bus.readdatavalid = 1'b0;
    settle();
    check("burst_fifo_empty", 64'(rd_outstanding), 64'd0);

    // Fill the tag FIFO with burstcount=0 reads; the 17th stalls until one returns.
    for (int n = 0; n < int'(DEPTH); n++) issue_read(2'd1, BW'(0));
    settle();
    check("full_outstanding", 64'(rd_outstanding), 64'd16);
    s_bus.read[1] = 1'b1;
    cyc();
    settle();
    check("full_stall_s_ready", 64'(s_bus.ready), 64'd0);
    check("full_stall_m_read", 64'(m_bus.read), 64'd0);
    cyc();
    m_bus.readdatavalid = 1'b1;
    settle();
    check("full_pop_s_ready", 64'(s_bus.ready), 64'd0);
    check("full_pop_rdv", 64'(s_bus.readdatavalid), 64'h2);
    cyc();
    m_bus.readdatavalid = 1'b0;
    settle();
    check("unstall_s_ready", 64'(s_bus.ready), 64'h2);
    check("unstall_m_read", 64'(m_bus.read), 64'd1);
    check("unstall_outstanding", 64'(rd_outstanding), 64'd15);
    cyc();
    s_bus.read = '0;
    settle();
    check("refill_outstanding", 64'(rd_outstanding), 64'd16);
    m_bus.readdatavalid = 1'b1;
    for (int n = 0; n < int'(DEPTH); n++) begin
      settle();
      check($sformatf("drain%0d_rdv", n), 64'(s_bus.readdatavalid), 64'h2);
      cyc();
    end
    m_bus.readdatavalid = 1'b0;
    settle();
    check("drain_outstanding", 64'(rd_outstanding), 64'd0);

    // Orphan return beats: sticky flag, no routing, cleared only by reset.
    m_bus.readdatavalid = 1'b1;
    settle();
    check("orphan_rdv", 64'(s_bus.readdatavalid), 64'd0);
    cyc();
    m_bus.readdatavalid = 1'b0;
    settle();
    check("orphan_set", 64'(rd_orphan_err), 64'd1);
    cyc();
    cyc();
    settle();
    check("orphan_sticky", 64'(rd_orphan_err), 64'd1);
    issue_read(2'd0, BW'(1));
    settle();
    check("pre_rst_outstanding", 64'(rd_outstanding), 64'd1);
    rst_n = 1'b0;
    cyc();
    settle();
    check("orphan_rst_clear", 64'(rd_orphan_err), 64'd0);
    check("rst_discard_outstanding", 64'(rd_outstanding), 64'd0);
    rst_n = 1'b1;
    m_bus.readdatavalid = 1'b1;
    settle();
    check("discarded_read_rdv", 64'(s_bus.readdatavalid), 64'd0);
    cyc();
    m_bus.readdatavalid = 1'b0;
    settle();
    check("discarded_read_orphan", 64'(rd_orphan_err), 64'd1);

    // Reset during beat 3 of an 8-beat write; port 2 is granted after release.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    s_bus.burstcount[0*BW +: BW] = BW'(8);
    s_bus.write = 4'b0001;
    cyc();
    cyc();
    cyc();
    rst_n = 1'b0;
    settle();
    check("mid_wr_m_write", 64'(m_bus.write), 64'd1);
    cyc();
    settle();
    check("mid_rst_s_ready", 64'(s_bus.ready), 64'd0);
    check("mid_rst_m_write", 64'(m_bus.write), 64'd0);
    check("mid_rst_m_read", 64'(m_bus.read), 64'd0);
    s_bus.write = '0;
    s_bus.read  = 4'b0100;
    rst_n = 1'b1;
    settle();
    check("post_rst_idle_m_read", 64'(m_bus.read), 64'd0);
    cyc();
    settle();
    check("post_rst_p2_s_ready", 64'(s_bus.ready), 64'h4);
    check("post_rst_p2_m_read", 64'(m_bus.read), 64'd1);
    check("post_rst_p2_addr", 64'(m_bus.address), 64'h102);
    cyc();
    s_bus.read = '0;
    m_bus.readdatavalid = 1'b1;
    settle();
    check("post_rst_p2_rdv", 64'(s_bus.readdatavalid), 64'h4);
    cyc();
    m_bus.readdatavalid = 1'b0;

    // Write with burstcount=0 is a single beat.
    s_bus.burstcount[3*BW +: BW] = BW'(0);
    s_bus.write = 4'b1000;
    cyc();
    settle();
    check("wr_bc0_m_write", 64'(m_bus.write), 64'd1);
    check("wr_bc0_s_ready", 64'(s_bus.ready), 64'h8);
    cyc();
    s_bus.write = '0;
    settle();
    check("wr_bc0_done", 64'(s_bus.ready), 64'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
